// File: rtl/mem_wb_pkg.sv
// rtl/mem_wb_pkg.sv - shared constants and beat layout for the MEM/WB segment
package mem_wb_pkg;

    // Bit positions inside the control bundle
    localparam int CTRL_MEMTOREG  = 0;
    localparam int CTRL_REGSWRITE = 1;
    localparam int CTRL_REGVWRITE = 2;

    localparam int CTRL_W_DEF = 3;
    localparam int LANES_DEF  = 12;
    localparam int LANE_W_DEF = 16;
    localparam int RR_W_DEF   = 4;

    // Field order matches the flat packing used by the segment top
    typedef struct packed {
        logic [CTRL_W_DEF-1:0]           ctrl;
        logic [LANES_DEF*LANE_W_DEF-1:0] mem;
        logic [LANES_DEF*LANE_W_DEF-1:0] alu;
        logic [LANES_DEF-1:0]            lane_en;
        logic [RR_W_DEF-1:0]             rr;
    } wb_beat_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - generic 2-entry skid buffer with flush and occupancy
module pipe_skid_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              m_valid_q, m_valid_d;
    logic              s_valid_q, s_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic              acc, pop;

    // Ready depends only on registered skid state and reset, never on out_ready
    assign in_ready  = rst && !s_valid_q;
    assign acc       = in_valid && in_ready;
    assign pop       = m_valid_q && out_ready;
    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;
    assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};

    // Next-state: pop drains skid first so beats stay in arrival order
    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_data_d  = m_data_q;
        s_data_d  = s_data_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (pop && s_valid_q) begin
            m_data_d  = s_data_q;
            s_valid_d = 1'b0;
        end else if (pop && acc) begin
            m_data_d  = in_data;
        end else if (pop) begin
            m_valid_d = 1'b0;
        end else if (acc && !m_valid_q) begin
            m_valid_d = 1'b1;
            m_data_d  = in_data;
        end else if (acc) begin
            s_valid_d = 1'b1;
            s_data_d  = in_data;
        end
    end

    // State register on the falling edge, shared with the other segments
    always_ff @(negedge clk) begin
        if (!rst) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            m_data_q  <= '0;
            s_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            m_data_q  <= m_data_d;
            s_data_q  <= s_data_d;
        end
    end

endmodule

// File: rtl/segment_skid_mem_wb.sv
// rtl/segment_skid_mem_wb.sv - MEM/WB pipeline segment with skid buffer, gating and stall counter
module segment_skid_mem_wb
    import mem_wb_pkg::*;
#(
    parameter int CTRL_W      = CTRL_W_DEF,
    parameter int LANES       = LANES_DEF,
    parameter int LANE_W      = LANE_W_DEF,
    parameter int RR_W        = RR_W_DEF,
    parameter int STALL_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [LANES*LANE_W-1:0] in_mem,
    input  logic [LANES*LANE_W-1:0] in_alu,
    input  logic [LANES-1:0]        in_lane_en,
    input  logic [RR_W-1:0]         in_rr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [LANES*LANE_W-1:0] out_mem,
    output logic [LANES*LANE_W-1:0] out_alu,
    output logic [LANES-1:0]        out_lane_en,
    output logic [RR_W-1:0]         out_rr,
    output logic [1:0]              occupancy,
    output logic [STALL_CNT_W-1:0]  stall_cnt
);

    localparam int PW     = LANES * LANE_W;
    localparam int DATA_W = CTRL_W + 2 * PW + LANES + RR_W;

    logic [DATA_W-1:0]      beat_in, beat_out;
    logic [CTRL_W-1:0]      m_ctrl;
    logic [LANES-1:0]       m_lane_en;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Flat packing follows the wb_beat_t field order
    assign beat_in = {in_ctrl, in_mem, in_alu, in_lane_en, in_rr};
    assign {m_ctrl, out_mem, out_alu, m_lane_en, out_rr} = beat_out;

    pipe_skid_buf #(.DATA_W(DATA_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (beat_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (beat_out),
        .occupancy (occupancy)
    );

    // Bubbles must not write anything in WB
    assign out_ctrl    = m_ctrl & {CTRL_W{out_valid}};
    assign out_lane_en = m_lane_en & {LANES{out_valid}};
    assign stall_cnt   = stall_cnt_q;

    // Saturating count of cycles where WB refuses a valid beat
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Counter register; flush deliberately leaves it untouched
    always_ff @(negedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_segment_skid_mem_wb.sv
// tb/tb_segment_skid_mem_wb.sv - table-driven bench for segment_skid_mem_wb
module tb_segment_skid_mem_wb;

    localparam int CTRL_W = 3;
    localparam int LANES  = 12;
    localparam int LANE_W = 16;
    localparam int RR_W   = 4;
    localparam int PW     = LANES * LANE_W;

    logic              clk = 1'b1;
    logic              rst, flush, in_valid, out_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [PW-1:0]     in_mem, in_alu;
    logic [LANES-1:0]  in_lane_en;
    logic [RR_W-1:0]   in_rr;

    logic              in_ready, out_valid;
    logic [CTRL_W-1:0] out_ctrl;
    logic [PW-1:0]     out_mem, out_alu;
    logic [LANES-1:0]  out_lane_en;
    logic [RR_W-1:0]   out_rr;
    logic [1:0]        occupancy;
    logic [15:0]       stall_cnt;

    logic              s_in_ready, s_out_valid;
    logic [CTRL_W-1:0] s_out_ctrl;
    logic [PW-1:0]     s_out_mem, s_out_alu;
    logic [LANES-1:0]  s_out_lane_en;
    logic [RR_W-1:0]   s_out_rr;
    logic [1:0]        s_occupancy;
    logic [3:0]        s_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    segment_skid_mem_wb dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_mem(in_mem), .in_alu(in_alu), .in_lane_en(in_lane_en),
        .in_rr(in_rr), .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_mem(out_mem), .out_alu(out_alu), .out_lane_en(out_lane_en), .out_rr(out_rr),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    segment_skid_mem_wb #(.STALL_CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_ctrl(in_ctrl), .in_mem(in_mem), .in_alu(in_alu), .in_lane_en(in_lane_en),
        .in_rr(in_rr), .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl),
        .out_mem(s_out_mem), .out_alu(s_out_alu), .out_lane_en(s_out_lane_en), .out_rr(s_out_rr),
        .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
    );

    typedef struct {
        logic             rst, flush, iv, ordy;
        logic [3:0]       rr;
        logic [2:0]       ctrl;
        logic [11:0]      le;
        logic             e_ov;
        logic [3:0]       e_rr;
        logic [2:0]       e_ctrl;
        logic [11:0]      e_le;
        logic [1:0]       e_occ;
        logic             e_ir;
        logic [15:0]      e_stall;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [PW-1:0] alu_of(input logic [3:0] rr);
        logic [PW-1:0] v;
        v = '0;
        if (rr != 4'd0) begin
            for (int i = 0; i < LANES; i++) v[i*LANE_W +: LANE_W] = {rr, 4'h0, 8'(i)};
        end
        return v;
    endfunction

    function automatic logic [PW-1:0] mem_of(input logic [3:0] rr);
        logic [PW-1:0] v;
        v = '0;
        if (rr != 4'd0) v = alu_of(rr) ^ {LANES{16'hA5A5}};
        return v;
    endfunction

    function automatic void add(input logic r, f, iv, o, input logic [3:0] rr,
                                input logic [2:0] c, input logic [11:0] le,
                                input logic eov, input logic [3:0] err, input logic [2:0] ec,
                                input logic [11:0] ele, input logic [1:0] eocc,
                                input logic eir, input logic [15:0] est);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.ordy = o; v.rr = rr; v.ctrl = c; v.le = le;
        v.e_ov = eov; v.e_rr = err; v.e_ctrl = ec; v.e_le = ele; v.e_occ = eocc;
        v.e_ir = eir; v.e_stall = est;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, f, iv, o, input logic [3:0] rr,
                         input logic [2:0] c, input logic [11:0] le);
        rst = r; flush = f; in_valid = iv; out_ready = o; in_rr = rr;
        in_ctrl = c; in_lane_en = le; in_alu = alu_of(rr); in_mem = mem_of(rr);
    endtask

    // Inputs change at the rising edge; the DUT updates on the falling edge
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 12'd0);

        // rst flush iv ordy rr ctrl le | ov rr ctrl le occ ir stall
        for (int i = 0; i < 3; i++)
            add(0,0,1,0, 4'd15, 3'b111, 12'hFFF,  0, 4'd0, 3'd0, 12'h000, 2'd0, 0, 16'd0);
        add(1,0,0,0, 4'd0, 3'b000, 12'h000,        0, 4'd0, 3'd0, 12'h000, 2'd0, 1, 16'd0);
        for (int r = 1; r <= 5; r++)
            add(1,0,1,1, 4'(r), 3'b011, 12'hABC,   1, 4'(r), 3'b011, 12'hABC, 2'd1, 1, 16'd0);
        add(1,0,0,1, 4'd0, 3'b011, 12'hABC,        0, 4'd5, 3'd0, 12'h000, 2'd0, 1, 16'd0);
        add(1,0,1,0, 4'd7, 3'b101, 12'h0F0,        1, 4'd7, 3'b101, 12'h0F0, 2'd1, 1, 16'd0);
        add(1,0,1,0, 4'd8, 3'b101, 12'h0F0,        1, 4'd7, 3'b101, 12'h0F0, 2'd2, 0, 16'd1);
        add(1,0,1,0, 4'd9, 3'b101, 12'h0F0,        1, 4'd7, 3'b101, 12'h0F0, 2'd2, 0, 16'd2);
        add(1,0,1,1, 4'd9, 3'b101, 12'h0F0,        1, 4'd8, 3'b101, 12'h0F0, 2'd1, 1, 16'd2);
        add(1,0,1,1, 4'd9, 3'b101, 12'h0F0,        1, 4'd9, 3'b101, 12'h0F0, 2'd1, 1, 16'd2);
        add(1,0,0,1, 4'd0, 3'b101, 12'h0F0,        0, 4'd9, 3'd0, 12'h000, 2'd0, 1, 16'd2);
        add(1,0,1,0, 4'd3, 3'b111, 12'h00F,        1, 4'd3, 3'b111, 12'h00F, 2'd1, 1, 16'd2);
        add(1,0,1,0, 4'd4, 3'b111, 12'h00F,        1, 4'd3, 3'b111, 12'h00F, 2'd2, 0, 16'd3);
        add(1,1,1,0, 4'd10, 3'b111, 12'h00F,       0, 4'd3, 3'd0, 12'h000, 2'd0, 1, 16'd4);
        add(1,0,0,0, 4'd10, 3'b111, 12'h00F,       0, 4'd3, 3'd0, 12'h000, 2'd0, 1, 16'd4);
        add(1,0,1,1, 4'd6, 3'b110, 12'hFFF,        1, 4'd6, 3'b110, 12'hFFF, 2'd1, 1, 16'd4);
        add(1,0,0,1, 4'd0, 3'b110, 12'hFFF,        0, 4'd6, 3'd0, 12'h000, 2'd0, 1, 16'd4);
        add(1,0,1,0, 4'd2, 3'b011, 12'h001,        1, 4'd2, 3'b011, 12'h001, 2'd1, 1, 16'd4);
        add(0,1,1,0, 4'd5, 3'b011, 12'h001,        0, 4'd0, 3'd0, 12'h000, 2'd0, 0, 16'd0);
        add(1,0,0,0, 4'd0, 3'b000, 12'h000,        0, 4'd0, 3'd0, 12'h000, 2'd0, 1, 16'd0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].ordy, tbl[i].rr,
                  tbl[i].ctrl, tbl[i].le);
            tick();
            chk($sformatf("v%0d out_valid", i), 256'(out_valid), 256'(tbl[i].e_ov));
            chk($sformatf("v%0d out_rr", i), 256'(out_rr), 256'(tbl[i].e_rr));
            chk($sformatf("v%0d out_alu", i), 256'(out_alu), 256'(alu_of(tbl[i].e_rr)));
            chk($sformatf("v%0d out_mem", i), 256'(out_mem), 256'(mem_of(tbl[i].e_rr)));
            chk($sformatf("v%0d out_ctrl", i), 256'(out_ctrl), 256'(tbl[i].e_ctrl));
            chk($sformatf("v%0d out_lane_en", i), 256'(out_lane_en), 256'(tbl[i].e_le));
            chk($sformatf("v%0d occupancy", i), 256'(occupancy), 256'(tbl[i].e_occ));
            chk($sformatf("v%0d in_ready", i), 256'(in_ready), 256'(tbl[i].e_ir));
            chk($sformatf("v%0d stall_cnt", i), 256'(stall_cnt), 256'(tbl[i].e_stall));
        end

        // Saturation: one beat held against a stalled WB for 20 edges
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 12'd0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 3'b001, 12'h001);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 3'b001, 12'h001);
        for (int i = 0; i < 20; i++) tick();
        chk("sat small 20", 256'(s_stall_cnt), 256'(4'd15));
        chk("sat wide 20", 256'(stall_cnt), 256'(16'd20));
        for (int i = 0; i < 3; i++) tick();
        chk("sat small hold", 256'(s_stall_cnt), 256'(4'd15));
        chk("sat wide 23", 256'(stall_cnt), 256'(16'd23));
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 3'b001, 12'h001);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 3'b001, 12'h001);
        tick();
        chk("flush keeps stall", 256'(stall_cnt), 256'(16'd24));
        chk("flush keeps sat", 256'(s_stall_cnt), 256'(4'd15));
        chk("flush empties", 256'(s_occupancy), 256'(2'd0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/segment_skid_mem_wb.md
Name: segment_skid_mem_wb

Overview:
- Parametrised MEM/WB pipeline segment with a valid/ready handshake and a 2-entry skid buffer, so the writeback stage can stall without a combinational ready path back into MEM.
- Carries control bits, vector mem/alu lane data, a lane write-enable mask and the destination register index.
- Adds flush, bubble gating of write enables, an occupancy output and a saturating stall counter.

Parameters:
- CTRL_W, 3, control bundle width; bit0 MemToReg, bit1 RegSWrite, bit2 RegVWrite.
- LANES, 12, number of vector lanes.
- LANE_W, 16, bits per lane; payload width is LANES*LANE_W (192 by default).
- RR_W, 4, destination register index width.
- STALL_CNT_W, 16, stall counter width.

Ports:
- clk  in  1  pipeline clock; all state updates on the falling edge, matching the other pipeline segments.
- rst  in  1  synchronous, active-low reset; asserted when 0 and sampled on the active clk edge.
- flush  in  1  discard all held and incoming beats.
- in_valid  in  1  MEM beat valid.
- in_ready  out  1  stage can accept a beat.
- in_ctrl  in  CTRL_W  control bundle.
- in_mem  in  LANES*LANE_W  memory read data.
- in_alu  in  LANES*LANE_W  ALU result.
- in_lane_en  in  LANES  per-lane write enable.
- in_rr  in  RR_W  destination register.
- out_valid  out  1  WB beat valid.
- out_ready  in  1  WB consumes the beat.
- out_ctrl  out  CTRL_W  control bundle, gated by out_valid.
- out_mem  out  LANES*LANE_W  memory data.
- out_alu  out  LANES*LANE_W  ALU result.
- out_lane_en  out  LANES  lane mask, gated by out_valid.
- out_rr  out  RR_W  destination register.
- occupancy  out  2  beats held, 0..2.
- stall_cnt  out  STALL_CNT_W  count of out_valid&&!out_ready cycles, saturating.

Behaviour:
- Storage:
  - main register (m_valid, m_payload) drives the out_* ports.
  - skid register (s_valid, s_payload) holds an overflow beat.
- Handshake:
  - in_ready = rst && !s_valid. This is a pure register output: no combinational path from out_ready.
  - acc = in_valid && in_ready.
  - pop = m_valid && out_ready.
- Per-edge update when rst=1 and flush=0:
  - pop=0, acc=1, m_valid=0: the beat loads into main.
  - pop=0, acc=1, m_valid=1: the beat loads into skid (s_valid=1).
  - pop=1, s_valid=1: skid moves to main; s_valid=0. acc is 0 here because in_ready=0.
  - pop=1, acc=1, s_valid=0: the new beat loads into main; m_valid stays 1.
  - pop=1, acc=0, s_valid=0: m_valid=0.
  - otherwise: hold.
- Ordering: beats leave in arrival order. Skid is never loaded while main is empty.
- Latency:
  - 1 edge from acceptance to out_valid when the stage was empty.
  - Full throughput: one beat per cycle when out_ready is held at 1.
- Output gating:
  - out_ctrl = m_ctrl & {CTRL_W{m_valid}}.
  - out_lane_en = m_lane_en & {LANES{m_valid}}.
  - out_mem, out_alu and out_rr hold their last value while invalid; they are never X after reset.
- occupancy = m_valid + s_valid, computed combinationally from the registers.
- stall_cnt:
  - Increments on each edge where out_valid && !out_ready.
  - Saturates at all-ones.
  - Clears only on reset; flush does not clear it.
- Flush (rst=1, flush=1):
  - m_valid and s_valid clear on the edge and any incoming beat is dropped; flush has priority over acc and pop.
  - Payload registers are not cleared.
  - in_ready is 1 on the cycle after the flush edge.
- Reset (rst=0 on an edge):
  - m_valid, s_valid and all payload registers clear to 0.
  - Consequently out_valid=0, out_ctrl=0, out_lane_en=0, out_mem=0, out_alu=0, out_rr=0, occupancy=0, stall_cnt=0.
  - in_ready is 0 combinationally while rst=0.
  - Reset mid-stream drops held beats with no partial output.
- Simultaneous flush and reset: reset wins.
- Both payload fields are carried independently; MemToReg selection is done in WB, not here.

Decomposition:
- Package mem_wb_pkg:
  - CTRL_MEMTOREG=0, CTRL_REGSWRITE=1, CTRL_REGVWRITE=2.
  - Default LANES, LANE_W, RR_W.
  - packed struct wb_beat_t {ctrl, mem, alu, lane_en, rr}.
- One natural sub-module, pipe_skid_buf: a generic 2-entry skid buffer over an opaque DATA_W vector with valid/ready/flush/occupancy. The top packs wb_beat_t into it and adds output gating and stall_cnt.

Test Plan:
- Reset: hold rst=0 for 3 edges with in_valid=1 -> out_valid=0, out_ctrl=0, occupancy=0, in_ready=0; after release, in_ready=1.
- Streaming: out_ready=1, send beats rr=1..5 with alu=lane-index pattern -> out_rr=1..5 on consecutive cycles, occupancy stays 1, stall_cnt=0.
- Backpressure: out_ready=0, send 3 beats (rr=7,8,9) -> accept 7 and 8, in_ready=0 after the 2nd edge, occupancy=2, 9 is held by the source; release out_ready -> order 7,8,9 with no loss; stall_cnt equals the stalled cycles.
- Flush: occupancy=2, assert flush with in_valid=1 (rr=A) -> next edge out_valid=0, occupancy=0, A is never emitted, out_ctrl=0, out_lane_en=0.
- Gating: beat with ctrl=3'b110, lane_en=12'hFFF, then bubble -> during the bubble out_ctrl=0 and out_lane_en=0 while out_alu keeps the prior value.
- Saturation: STALL_CNT_W=4, stall 20 cycles -> stall_cnt=15 and it holds at 15.
